multicycle_ctrl: RTL and testbench

//  Moore FSM sequencing the multicycle MIPS datapath (shared memory, IR, A/B/ALUOut regs).
//  Per instruction: steps fetch, decode, execute, memory and writeback over 3-5 states.

---
 rtl/multicycle_ctrl_pkg.sv | 60 ++++++
 rtl/multicycle_ctrl.sv | 160 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, FSM state codes,
// datapath select encodings and the packed control-word layout.
package multicycle_ctrl_pkg;

    localparam logic [5:0] R_FORMAT = 6'b000000;
    localparam logic [5:0] LW       = 6'b100011;
    localparam logic [5:0] SW       = 6'b101011;
    localparam logic [5:0] BEQ      = 6'b000100;
    localparam logic [5:0] J        = 6'b000010;

    localparam logic [3:0] S_START  = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_REX    = 4'd7;
    localparam logic [3:0] S_RWB    = 4'd8;
    localparam logic [3:0] S_BEQ    = 4'd9;
    localparam logic [3:0] S_JMP    = 4'd10;
    localparam logic [3:0] S_HALT   = 4'd11;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       halted;
    } ctrl_t;

    // States whose exit completes an instruction (MEMWR only once memory is ready).
    function automatic logic is_final_state(input logic [3:0] st, input logic ready);
        return (st == S_MEMWB) || (st == S_RWB) || (st == S_BEQ) || (st == S_JMP) ||
               ((st == S_MEMWR) && ready);
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Moore FSM sequencing the multicycle MIPS datapath, with a retired-instruction
// counter and a sticky halt on illegal opcodes.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned RET_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             halted,
    output logic [RET_W-1:0] retired
);

    localparam logic [RET_W-1:0] RET_ONE = RET_W'(1);

    logic [3:0]       state_q, state_d;
    logic [RET_W-1:0] retired_q;
    ctrl_t            ctrl;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_START;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_START:  state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    LW, SW:   state_d = S_MEMADR;
                    R_FORMAT: state_d = S_REX;
                    BEQ:      state_d = S_BEQ;
                    J:        state_d = S_JMP;
                    default:  state_d = S_HALT;
                endcase
            end
            S_MEMADR: begin
                if (op == LW) begin
                    state_d = S_MEMRD;
                end else if (op == SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_REX:    state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BEQ:    state_d = S_FETCH;
            S_JMP:    state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
    end

    // Pure state decode; mem_ready only gates the fetch-side loads.
    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMMSH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_REX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_HALT:  ctrl.halted = 1'b1;
            default: ctrl = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retired_q <= '0;
        end else if (is_final_state(state_q, mem_ready)) begin
            retired_q <= retired_q + RET_ONE;
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign halted        = ctrl.halted;
    assign retired       = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by cycle,
// plus halt, mid-instruction reset and counter wrap on a narrow build.
module tb_multicycle_ctrl;

    // Control word: pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
    // mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[2], alu_op[2], pc_source[2], halted
    localparam logic [16:0] C_START  = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_FETCH  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_FWAIT  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_DECODE = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] C_MEMADR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] C_MEMRD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_MEMWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] C_MEMWR  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_REX    = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] C_RWB    = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] C_BEQ    = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] C_JMP    = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] C_HALT   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    logic        clock;
    logic        reset;
    logic [5:0]  op;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, halted;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [31:0] retired;

    logic        reset_n4;
    logic        pc_write4, pc_write_cond4, iord4, mem_read4, mem_write4, ir_write4;
    logic        mem_to_reg4, reg_dst4, reg_write4, alu_src_a4, halted4;
    logic [1:0]  alu_src_b4, alu_op4, pc_source4;
    logic [3:0]  retired4;

    int total;
    int bad;

    logic [16:0] ctrl;
    assign ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                   reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, halted};

    multicycle_ctrl #(.RET_W(32)) dut (
        .clock(clock), .reset(reset), .op(op), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .halted(halted), .retired(retired)
    );

    // Narrow counter build, always running J instructions with memory ready.
    multicycle_ctrl #(.RET_W(4)) dut4 (
        .clock(clock), .reset(reset_n4), .op(OP_J), .mem_ready(1'b1),
        .pc_write(pc_write4), .pc_write_cond(pc_write_cond4), .iord(iord4),
        .mem_read(mem_read4), .mem_write(mem_write4), .ir_write(ir_write4),
        .mem_to_reg(mem_to_reg4), .reg_dst(reg_dst4), .reg_write(reg_write4),
        .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4), .alu_op(alu_op4),
        .pc_source(pc_source4), .halted(halted4), .retired(retired4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk_ctrl(input string tag, input logic [16:0] exp);
        total++;
        assert (ctrl === exp) else begin
            bad++;
            $error("FAIL %s ctrl observed=%b expected=%b", tag, ctrl, exp);
        end
    endtask

    task automatic chk_ret(input string tag, input logic [31:0] exp);
        total++;
        assert (retired === exp) else begin
            bad++;
            $error("FAIL %s retired observed=%0d expected=%0d", tag, retired, exp);
        end
    endtask

    // One cycle in the current state: apply mem_ready, check, advance to just after the edge.
    task automatic step(input string tag, input logic rdy, input logic [16:0] exp,
                        input logic [31:0] exp_ret);
        mem_ready = rdy;
        #1;
        chk_ctrl(tag, exp);
        chk_ret(tag, exp_ret);
        @(posedge clock);
        #1;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        reset_n4 = 1'b0;
        op       = OP_R;
        mem_ready = 1'b1;
        #12;
        chk_ctrl("reset_ctrl", C_START);
        chk_ret("reset_ret", 32'd0);
        reset = 1'b1;

        // R-type
        step("r_start", 1'b1, C_START, 0);
        step("r_fetch", 1'b1, C_FETCH, 0);
        step("r_decode", 1'b0, C_DECODE, 0);
        step("r_rex", 1'b1, C_REX, 0);
        step("r_rwb", 1'b1, C_RWB, 0);

        // LW with fetch and memory waits: 10 cycles
        op = OP_LW;
        step("lw_fwait0", 1'b0, C_FWAIT, 1);
        step("lw_fwait1", 1'b0, C_FWAIT, 1);
        step("lw_fwait2", 1'b0, C_FWAIT, 1);
        step("lw_fetch", 1'b1, C_FETCH, 1);
        step("lw_decode", 1'b1, C_DECODE, 1);
        step("lw_memadr", 1'b0, C_MEMADR, 1);
        step("lw_memrd_w0", 1'b0, C_MEMRD, 1);
        step("lw_memrd_w1", 1'b0, C_MEMRD, 1);
        step("lw_memrd", 1'b1, C_MEMRD, 1);
        step("lw_memwb", 1'b0, C_MEMWB, 1);

        // SW with one write wait
        op = OP_SW;
        step("sw_fetch", 1'b1, C_FETCH, 2);
        step("sw_decode", 1'b1, C_DECODE, 2);
        step("sw_memadr", 1'b1, C_MEMADR, 2);
        step("sw_memwr_w", 1'b0, C_MEMWR, 2);
        step("sw_memwr", 1'b1, C_MEMWR, 2);

        op = OP_BEQ;
        step("beq_fetch", 1'b1, C_FETCH, 3);
        step("beq_decode", 1'b1, C_DECODE, 3);
        step("beq_beq", 1'b0, C_BEQ, 3);

        op = OP_J;
        step("j_fetch", 1'b1, C_FETCH, 4);
        step("j_decode", 1'b1, C_DECODE, 4);
        step("j_jmp", 1'b1, C_JMP, 4);

        // Reset between edges while a store waits
        op = OP_SW;
        step("rst_fetch", 1'b1, C_FETCH, 5);
        step("rst_decode", 1'b1, C_DECODE, 5);
        step("rst_memadr", 1'b1, C_MEMADR, 5);
        mem_ready = 1'b0;
        #1;
        chk_ctrl("rst_memwr_pre", C_MEMWR);
        #1;
        reset = 1'b0;
        #1;
        chk_ctrl("rst_memwr_abort", C_START);
        chk_ret("rst_memwr_ret", 32'd0);
        @(posedge clock);
        #1;
        chk_ctrl("rst_held", C_START);
        reset = 1'b1;

        // Illegal opcode halts until reset
        op = OP_BAD;
        step("bad_start", 1'b1, C_START, 0);
        step("bad_fetch", 1'b1, C_FETCH, 0);
        step("bad_decode", 1'b1, C_DECODE, 0);
        for (int i = 0; i < 20; i++) begin
            op = (i % 2 == 0) ? OP_R : OP_LW;
            step("halt_hold", 1'(i % 2), C_HALT, 0);
        end
        reset = 1'b0;
        #1;
        chk_ctrl("halt_reset", C_START);
        reset = 1'b1;

        // RET_W=4: sixteen J instructions wrap the counter back to zero
        reset_n4 = 1'b1;
        repeat (46) @(posedge clock);
        #1;
        total++;
        assert (retired4 === 4'd15) else begin
            bad++;
            $error("FAIL wrap_pre retired4 observed=%0d expected=15", retired4);
        end
        repeat (3) @(posedge clock);
        #1;
        total++;
        assert (retired4 === 4'd0) else begin
            bad++;
            $error("FAIL wrap retired4 observed=%0d expected=0", retired4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
